drap_pc_unit: RTL and testbench
===============================

DRAP_PC_UNIT -- requirements
Module: drap_pc_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have parameter BOOT_CYCLES, default 2, the idle cycles after reset release before the first fetch request.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port stall  input  1  holds the PC and suppresses the fetch request.
REQ-006 SHALL have port branch_taken  input  1  selects the branch target this cycle.
REQ-007 SHALL have port shl2  input  32  word-shifted sign-extended branch offset.
REQ-008 SHALL have port jump  input  1  selects the J-type target.
REQ-009 SHALL have port jump_index  input  26  J-type instruction index.
REQ-010 SHALL have port jr  input  1  selects the register target.
REQ-011 SHALL have port jr_addr  input  32  register jump address.
REQ-012 SHALL have port imem_ready  input  1  instruction memory accepted the current fetch.
REQ-013 SHALL have port pc  output  32  current fetch address.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, combinational.
REQ-015 SHALL have port imem_req  output  1  fetch request for pc.
REQ-016 SHALL have port flush  output  1  one-cycle pulse when a redirect is committed.
REQ-017 SHALL have port misalign_err  output  1  sticky flag for a misaligned jr_addr.

Function
REQ-018 SHALL implement FSM states BOOT, FETCH, HOLD; reset enters BOOT.
REQ-019 In BOOT, SHALL count BOOT_CYCLES cycles with imem_req=0, then go to FETCH.
REQ-020 In FETCH, SHALL assert imem_req=1; if stall=1 it SHALL go to HOLD and leave pc unchanged.
REQ-021 In HOLD, SHALL drive imem_req=0 and return to FETCH on the first cycle with stall=0.
REQ-022 Next-PC priority SHALL be: pending redirect, then jr, then jump, then branch_taken, then sequential.
REQ-023 Branch target SHALL be pc_plus4 + shl2, modulo 2^32, with no overflow detection.
REQ-024 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-025 The jr target SHALL be {jr_addr[31:2], 2'b00}; if jr_addr[1:0] != 0, misalign_err SHALL set and stay set until reset.
REQ-026 pc SHALL update only in FETCH on a cycle with imem_ready=1 and stall=0; latency from fetch accept to new pc is 1 cycle.
REQ-027 A redirect (jr, jump or branch_taken) arriving while imem_ready=0 or in HOLD SHALL be latched into a one-entry pending buffer and applied at the next pc update.
REQ-028 A newer redirect SHALL overwrite the pending entry; the pending entry SHALL clear when applied.
REQ-029 flush SHALL pulse for exactly the one cycle following any pc update that took a redirect target.
REQ-030 Sequential increment SHALL wrap: 32'hFFFF_FFFC becomes 32'h0000_0000.
REQ-031 Redirect inputs SHALL be ignored in BOOT.

Reset
REQ-032 On rst_n=0, at any time including mid-fetch, SHALL asynchronously set: pc=RESET_VECTOR, imem_req=0, flush=0, misalign_err=0, pending buffer empty, boot counter 0, state BOOT.
REQ-033 Deassertion of rst_n SHALL be sampled on clk; the first fetch is issued BOOT_CYCLES cycles after deassertion.

Structure
REQ-034 FSM state encodings and the PC increment constant (4) SHALL reside in shared package drap_pkg.
REQ-035 Next-PC target selection SHALL be a combinational sub-module drap_npc_mux; the registers, FSM and pending buffer SHALL stay in drap_pc_unit.
REQ-036 shl2 SHALL connect directly to the output of the existing shift-left-2 stage with no re-shifting.

Verification
REQ-037 Reset then release with imem_ready=1 -> imem_req rises after 2 cycles; pc sequence 0x0, 0x4, 0x8.
REQ-038 pc=0x10, branch_taken=1, shl2=0x0001_5554 -> pc=0x0001_5568 and a flush pulse.
REQ-039 pc=0x1000_0040, jump=1, jump_index=0x0000100 -> pc=0x1000_0400.
REQ-040 Branch (shl2=0x8) at pc=0x20 while imem_ready=0 for 3 cycles -> pc holds 0x20, then becomes 0x2C when ready, flush pulses once.
REQ-041 jr=1, jr_addr=0x1003 -> pc=0x1000, misalign_err=1 until reset; stall=1 in FETCH -> pc frozen and imem_req=0.
REQ-042 pc=0xFFFF_FFFC sequential -> pc=0x0; rst_n low mid-wait -> pc=RESET_VECTOR immediately.

Source files
------------

// File: rtl/drap_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | drap_pkg : shared FSM encodings and PC constants for the PC unit |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package drap_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/drap_npc_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | drap_npc_mux : combinational next-PC target selection            |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module drap_npc_mux
  import drap_pkg::*;
(
  input  logic        i_enable,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_pend_valid,
  input  logic [31:0] i_pend_target,
  input  logic        i_jr,
  input  logic [29:0] i_jr_word,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic        i_branch,
  input  logic [31:0] i_shl2,
  output logic        o_req_valid,
  output logic [31:0] o_req_target,
  output logic        o_redirect,
  output logic [31:0] o_npc
);

  // o_req_* is this cycle's redirect alone, used to refill the pending buffer.
  always_comb begin
    o_req_valid  = i_enable & (i_jr | i_jump | i_branch);
    o_req_target = i_pc_plus4 + i_shl2;
    if (i_jr) begin
      o_req_target = {i_jr_word, 2'b00};
    end else if (i_jump) begin
      o_req_target = jump_target(i_pc_plus4, i_jump_index);
    end

    o_redirect = 1'b0;
    o_npc      = i_pc_plus4;
    if (i_pend_valid) begin
      o_redirect = 1'b1;
      o_npc      = i_pend_target;
    end else if (o_req_valid) begin
      o_redirect = 1'b1;
      o_npc      = o_req_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/drap_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | drap_pc_unit : PC register, fetch FSM and one-entry redirect buf |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module drap_pc_unit
  import drap_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] shl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        flush,
  output logic        misalign_err
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_boot_cnt;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic        r_flush;
  logic        r_err;

  logic [31:0] w_pc_plus4;
  logic        w_in_boot;
  logic        w_boot_done;
  logic        w_update;
  logic        w_req_valid;
  logic [31:0] w_req_target;
  logic        w_redirect;
  logic [31:0] w_npc;

  assign w_pc_plus4  = r_pc + PC_INC;
  assign w_in_boot   = (r_state == ST_BOOT);
  assign w_boot_done = ((r_boot_cnt + 32'd1) >= BOOT_CYCLES);
  assign w_update    = (r_state == ST_FETCH) & imem_ready & ~stall;

  drap_npc_mux u_npc_mux (
    .i_enable      (~w_in_boot),
    .i_pc_plus4    (w_pc_plus4),
    .i_pend_valid  (r_pend_valid),
    .i_pend_target (r_pend_target),
    .i_jr          (jr),
    .i_jr_word     (jr_addr[31:2]),
    .i_jump        (jump),
    .i_jump_index  (jump_index),
    .i_branch      (branch_taken),
    .i_shl2        (shl2),
    .o_req_valid   (w_req_valid),
    .o_req_target  (w_req_target),
    .o_redirect    (w_redirect),
    .o_npc         (w_npc)
  );

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    case (r_state)
      ST_BOOT:  if (w_boot_done) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = ~stall;
        if (stall) w_state_nxt = ST_HOLD;
      end
      ST_HOLD:  if (!stall) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_boot_cnt    <= 32'd0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
      r_flush       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_in_boot ? (r_boot_cnt + 32'd1) : 32'd0;
      r_flush    <= w_update & w_redirect;
      if (w_update) begin
        r_pc         <= w_npc;
        r_pend_valid <= 1'b0;
      end else if (w_req_valid) begin
        // Newest redirect wins; the PC is frozen, so its target stays valid.
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_req_target;
      end
      if (!w_in_boot && jr && (jr_addr[1:0] != 2'b00)) r_err <= 1'b1;
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign flush        = r_flush;
  assign misalign_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_drap_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_drap_pc_unit : directed + randomized bench with a ref model    |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module tb_drap_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] shl2 = 32'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'd0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = 32'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        flush;
  logic        misalign_err;

  drap_pc_unit #(.RESET_VECTOR(RV), .BOOT_CYCLES(BC)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .shl2         (shl2),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_req     (imem_req),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: boot countdown, "held" flag, pending-target queue.
  logic [31:0] m_pc;
  int          m_boot;
  bit          m_hold;
  bit          m_flush;
  bit          m_err;
  logic [31:0] m_pend[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_boot  = BC;
    m_hold  = 1'b0;
    m_flush = 1'b0;
    m_err   = 1'b0;
    m_pend.delete();
  endtask

  // Called at posedge+1; drives inputs, checks mid-cycle, advances the model.
  task automatic cycle(input bit st, input bit br, input logic [31:0] sh,
                       input bit jp, input logic [25:0] idx,
                       input bit j_r, input logic [31:0] ja, input bit rdy);
    bit          in_fetch;
    bit          have_req;
    logic [31:0] p4;
    logic [31:0] tgt;
    stall = st; branch_taken = br; shl2 = sh; jump = jp; jump_index = idx;
    jr = j_r; jr_addr = ja; imem_ready = rdy;
    #4;
    in_fetch = (m_boot == 0) && !m_hold;
    p4       = m_pc + 32'd4;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, p4);
    chk("imem_req", 32'(imem_req), 32'(in_fetch && !st));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    if (m_boot > 0) begin
      m_boot--;
      m_flush = 1'b0;
    end else begin
      have_req = j_r || jp || br;
      if (j_r)      tgt = {ja[31:2], 2'b00};
      else if (jp)  tgt = {p4[31:28], idx, 2'b00};
      else          tgt = p4 + sh;
      if (j_r && (ja[1:0] != 2'b00)) m_err = 1'b1;
      if (in_fetch && rdy && !st) begin
        if (m_pend.size() > 0) begin
          m_pc = m_pend.pop_front(); m_flush = 1'b1;
        end else if (have_req) begin
          m_pc = tgt; m_flush = 1'b1;
        end else begin
          m_pc = p4; m_flush = 1'b0;
        end
      end else begin
        m_flush = 1'b0;
        if (have_req) begin
          m_pend.delete();
          m_pend.push_back(tgt);
        end
      end
      m_hold = st;
    end
    @(posedge clk); #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1);
  endtask

  task automatic go_jr(input logic [31:0] a);
    cycle(0, 0, 32'd0, 0, 26'd0, 1, a, 1);
  endtask

  // Asynchronous reset asserted mid-cycle, released just after an edge.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    chk("por_pc", pc, RV);
    chk("por_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;

    // Boot then sequential fetch.
    seq(2);
    chk("boot_req", 32'(imem_req), 32'd1);
    seq(2);
    chk("seq_pc8", pc, 32'h0000_0008);
    seq(2);
    chk("seq_pc10", pc, 32'h0000_0010);

    // Branch.
    cycle(0, 1, 32'h0001_5554, 0, 26'd0, 0, 32'd0, 1);
    chk("br_pc", pc, 32'h0001_5568);
    chk("br_flush", 32'(flush), 32'd1);

    // Jump.
    go_jr(32'h1000_0040);
    chk("jr_pc", pc, 32'h1000_0040);
    cycle(0, 0, 32'd0, 1, 26'h0000100, 0, 32'd0, 1);
    chk("jump_pc", pc, 32'h1000_0400);

    // Branch while memory not ready.
    go_jr(32'h0000_0020);
    cycle(0, 1, 32'h0000_0008, 0, 26'd0, 0, 32'd0, 0);
    cycle(0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0);
    cycle(0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0);
    chk("wait_pc", pc, 32'h0000_0020);
    seq(1);
    chk("pend_pc", pc, 32'h0000_002C);
    chk("pend_flush", 32'(flush), 32'd1);
    seq(1);
    chk("pend_flush_end", 32'(flush), 32'd0);

    // Misaligned jr, then stall.
    go_jr(32'h0000_1003);
    chk("mis_pc", pc, 32'h0000_1000);
    chk("mis_err", 32'(misalign_err), 32'd1);
    cycle(1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1);
    cycle(1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1);
    cycle(0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1);
    chk("stall_pc", pc, 32'h0000_1000);
    seq(1);
    chk("stall_resume", pc, 32'h0000_1004);
    chk("err_sticky", 32'(misalign_err), 32'd1);

    // Wrap, then reset mid-wait.
    go_jr(32'hFFFF_FFFC);
    seq(1);
    chk("wrap_pc", pc, 32'h0000_0000);
    seq(1);
    cycle(0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0);
    reset_mid();

    // Pending overwrite: newest redirect wins.
    seq(2);
    cycle(0, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0400, 0);
    cycle(0, 0, 32'd0, 0, 26'd0, 1, 32'h0000_0800, 0);
    seq(1);
    chk("overwrite_pc", pc, 32'h0000_0800);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_mid();
      end else begin
        cycle($urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom,
              $urandom_range(0, 7) == 0, 26'($urandom),
              $urandom_range(0, 9) == 0,
              ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
              $urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
